// File: rtl/dac_protocolo.sv
// Serial transmitter for a 12-bit SYNC/SCLK/DIN DAC: converts a signed 16-bit
// sample to offset binary and shifts a 16-bit frame out MSB first.
module dac_protocolo #(
  parameter int         CLK_DIV = 4,
  parameter logic [1:0] PD      = 2'b00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [15:0] d_in,
  output logic        ready,
  output logic        done,
  output logic        sync,
  output logic        sclk,
  output logic        sdata
);

  localparam int             DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [14:0]   shreg_q, shreg_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          sync_q, sync_d;
  logic          sclk_q, sclk_d;
  logic          sdata_q, sdata_d;
  logic [15:0]   frame;
  logic          unused_lsbs;

  // Handshake: a sample is taken on the rising edge where valid && ready;
  // ready is high only in IDLE, and valid is ignored in every other state.
  assign frame       = {2'b00, PD, ~d_in[15], d_in[14:4]};
  assign unused_lsbs = ^d_in[3:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      sync_q    <= 1'b1;
      sclk_q    <= 1'b1;
      sdata_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      sync_q    <= sync_d;
      sclk_q    <= sclk_d;
      sdata_q   <= sdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    sync_d    = sync_q;
    sclk_d    = sclk_q;
    sdata_d   = sdata_q;
    case (state_q)
      IDLE: begin
        if (valid && ready_q) begin
          shreg_d   = frame[14:0];
          sdata_d   = frame[15];
          sync_d    = 1'b0;
          ready_d   = 1'b0;
          div_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          sclk_d    = ~sclk_q;
          if (sclk_q) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end else if (bit_cnt_q != 5'd16) begin
            sdata_d = shreg_q[14];
            shreg_d = {shreg_q[13:0], 1'b0};
          end else begin
            // Final rise closes the frame together with SYNC.
            sync_d    = 1'b1;
            sclk_d    = 1'b1;
            sdata_d   = 1'b0;
            done_d    = 1'b1;
            bit_cnt_d = '0;
            state_d   = GAP;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      GAP: begin
        // bit_cnt counts the two half-periods of SYNC-high time here.
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (bit_cnt_q[0]) begin
            bit_cnt_d = '0;
            ready_d   = 1'b1;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready = ready_q;
  assign done  = done_q;
  assign sync  = sync_q;
  assign sclk  = sclk_q;
  assign sdata = sdata_q;

endmodule

// File: tb/tb_dac_protocolo.sv
// Bench for dac_protocolo: three instances (CLK_DIV 4/PD 00, CLK_DIV 1, PD 11)
// checked against a frame-timeline model plus directed literal expectations.
module tb_dac_protocolo;

  logic        clk;
  logic        reset;
  logic [2:0]  valid_a;
  logic [15:0] d_in_a [3];
  logic [2:0]  ready_w, done_w, sync_w, sclk_w, sdata_w;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // model state
  logic        busy   [3] = '{default: 1'b0};
  int          n_a    [3] = '{default: 0};
  logic [15:0] frm    [3] = '{default: 16'h0};
  int          acc_cyc[3] = '{default: 0};
  logic [17:0] exp_q [$];
  int          acc_q1 [$];

  // pin-level capture
  logic        prev_sync [3] = '{default: 1'b1};
  logic        prev_sclk [3] = '{default: 1'b1};
  logic        prev_ready[3] = '{default: 1'b1};
  int          fall_cnt  [3] = '{default: 0};
  int          low_cnt   [3] = '{default: 0};
  int          high_run  [3] = '{default: 0};
  int          frames_seen[3] = '{default: 0};
  int          done_cnt  [3] = '{default: 0};
  int          sclk_edges[3] = '{default: 0};
  int          done_cyc  [3] = '{default: 0};
  int          ready_cyc [3] = '{default: 0};
  int          last_low  [3] = '{default: 0};
  int          last_falls[3] = '{default: 0};
  logic [15:0] shreg_c   [3] = '{default: 16'h0};
  logic [15:0] last_frame[3] = '{default: 16'h0};
  logic [15:0] hist1 [$];
  int          gap_q1 [$];

  dac_protocolo #(.CLK_DIV(4), .PD(2'b00)) u_dut0 (
    .clk(clk), .reset(reset), .valid(valid_a[0]), .d_in(d_in_a[0]),
    .ready(ready_w[0]), .done(done_w[0]), .sync(sync_w[0]), .sclk(sclk_w[0]), .sdata(sdata_w[0]));
  dac_protocolo #(.CLK_DIV(1), .PD(2'b00)) u_dut1 (
    .clk(clk), .reset(reset), .valid(valid_a[1]), .d_in(d_in_a[1]),
    .ready(ready_w[1]), .done(done_w[1]), .sync(sync_w[1]), .sclk(sclk_w[1]), .sdata(sdata_w[1]));
  dac_protocolo #(.CLK_DIV(4), .PD(2'b11)) u_dut2 (
    .clk(clk), .reset(reset), .valid(valid_a[2]), .d_in(d_in_a[2]),
    .ready(ready_w[2]), .done(done_w[2]), .sync(sync_w[2]), .sclk(sclk_w[2]), .sdata(sdata_w[2]));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cd_of(input int i);
    return (i == 1) ? 1 : 4;
  endfunction

  function automatic logic [1:0] pd_of(input int i);
    return (i == 2) ? 2'b11 : 2'b00;
  endfunction

  function automatic logic [15:0] frame_of(input int i, input logic [15:0] d);
    return {2'b00, pd_of(i), ~d[15], d[14:4]};
  endfunction

  function automatic logic [4:0] outs(input int i);
    return {ready_w[i], done_w[i], sync_w[i], sclk_w[i], sdata_w[i]};
  endfunction

  // {ready, done, sync, sclk, sdata} from the frame timeline: n clocks after accept
  function automatic logic [4:0] exp_outs(input int i);
    int cd;
    int n;
    cd = cd_of(i);
    n  = n_a[i];
    if (reset || !busy[i]) return 5'b10110;
    if (n >= 32 * cd) return {1'b0, (n == 32 * cd), 1'b1, 1'b1, 1'b0};
    return {1'b0, 1'b0, 1'b0, ((n / cd) % 2) == 0, frm[i][15 - n / (2 * cd)]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // model advance on the active edge
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        busy[i] = 1'b0;
      end else if (!busy[i]) begin
        if (valid_a[i]) begin
          busy[i]    = 1'b1;
          n_a[i]     = 0;
          frm[i]     = frame_of(i, d_in_a[i]);
          acc_cyc[i] = cyc;
          exp_q.push_back({2'(i), frm[i]});
          if (i == 1) acc_q1.push_back(cyc);
        end
      end else begin
        n_a[i]++;
        if (n_a[i] == 34 * cd_of(i)) busy[i] = 1'b0;
      end
    end
    if (reset) exp_q.delete();
  end

  // compare + capture on the opposite edge
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      check($sformatf("outs%0d", i), {27'd0, outs(i)}, {27'd0, exp_outs(i)});
      if (reset) begin
        prev_sync[i]  = 1'b1;
        prev_sclk[i]  = 1'b1;
        prev_ready[i] = 1'b1;
        fall_cnt[i]   = 0;
        low_cnt[i]    = 0;
        high_run[i]   = 0;
        shreg_c[i]    = 16'h0;
      end else begin
        if (sclk_w[i] !== prev_sclk[i]) sclk_edges[i]++;
        if (prev_sync[i] && !sync_w[i]) begin
          if (i == 1) gap_q1.push_back(high_run[i]);
          fall_cnt[i] = 0;
          low_cnt[i]  = 0;
          high_run[i] = 0;
        end
        if (!sync_w[i]) low_cnt[i]++;
        else high_run[i]++;
        if (prev_sclk[i] && !sclk_w[i] && !sync_w[i]) begin
          shreg_c[i] = {shreg_c[i][14:0], sdata_w[i]};
          fall_cnt[i]++;
        end
        if (!prev_sync[i] && sync_w[i]) begin
          frames_seen[i]++;
          last_frame[i] = shreg_c[i];
          last_low[i]   = low_cnt[i];
          last_falls[i] = fall_cnt[i];
          if (i == 1) hist1.push_back(shreg_c[i]);
          check($sformatf("falls%0d", i), fall_cnt[i], 16);
          if (exp_q.size() == 0) begin
            check("sb_nonempty", 0, 1);
          end else begin
            check($sformatf("sb_frame%0d", i), {14'd0, 2'(i), shreg_c[i]}, {14'd0, exp_q.pop_front()});
          end
        end
        if (done_w[i]) begin
          done_cnt[i]++;
          done_cyc[i] = cyc;
        end
        if (!prev_ready[i] && ready_w[i]) ready_cyc[i] = cyc;
        prev_sync[i]  = sync_w[i];
        prev_sclk[i]  = sclk_w[i];
        prev_ready[i] = ready_w[i];
      end
    end
  end

  // driver tasks (called at a falling clock edge)
  task automatic start(input int i, input logic [15:0] d);
    int t = 0;
    while (busy[i] && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check("start_timeout", 1, 0);
    valid_a[i] = 1'b1;
    d_in_a[i]  = d;
    @(negedge clk);
    valid_a[i] = 1'b0;
  endtask

  task automatic pulse(input int i, input logic [15:0] d);
    valid_a[i] = 1'b1;
    d_in_a[i]  = d;
    @(negedge clk);
    valid_a[i] = 1'b0;
  endtask

  task automatic wait_frames(input int i, input int target);
    int t = 0;
    while (frames_seen[i] < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) check("frame_timeout", 1, 0);
  endtask

  task automatic send(input int i, input logic [15:0] d, input logic [15:0] expf, input string name);
    int prev;
    prev = frames_seen[i];
    start(i, d);
    wait_frames(i, prev + 1);
    check(name, last_frame[i], expf);
  endtask

  initial begin
    int prev;
    int d0;
    int na;
    int h0;
    int t;
    reset   = 1'b1;
    valid_a = 3'b000;
    for (int i = 0; i < 3; i++) d_in_a[i] = 16'h0;
    repeat (3) @(negedge clk);
    check("reset_outs", {27'd0, outs(0)}, 32'h16);
    reset = 1'b0;

    repeat (50) @(negedge clk);
    check("idle_sclk_edges", sclk_edges[0] + sclk_edges[1] + sclk_edges[2], 0);
    check("idle_done", done_cnt[0], 0);

    // full-scale positive frame and its timing
    prev = frames_seen[0];
    start(0, 16'h7FFF);
    wait_frames(0, prev + 1);
    check("f7fff_bits", last_frame[0], 16'h0FFF);
    check("f7fff_sync_low", last_low[0], 128);
    check("f7fff_falls", last_falls[0], 16);
    check("f7fff_done_lat", done_cyc[0] - acc_cyc[0], 128);
    repeat (12) @(negedge clk);
    check("f7fff_ready_lat", ready_cyc[0] - acc_cyc[0], 136);

    // conversion sweep
    send(0, 16'h0000, 16'h0800, "conv_0000");
    send(0, 16'h8000, 16'h0000, "conv_8000");
    send(0, 16'hFFF0, 16'h07FF, "conv_fff0");
    send(0, 16'h123F, 16'h0923, "conv_123f");
    send(2, 16'h0000, 16'h3800, "conv_pd11");

    // valid held high, d_in changing every clock, CLK_DIV=1
    prev = frames_seen[1];
    na   = acc_q1.size();
    h0   = hist1.size();
    valid_a[1] = 1'b1;
    d_in_a[1]  = 16'h4000;
    repeat (109) begin
      @(negedge clk);
      d_in_a[1] = d_in_a[1] + 16'h1;
    end
    @(negedge clk);
    valid_a[1] = 1'b0;
    wait_frames(1, prev + 4);
    check("b2b_accepts", acc_q1.size() - na, 4);
    if (acc_q1.size() >= na + 4) begin
      for (int k = 0; k < 3; k++) check("b2b_period", acc_q1[na + k + 1] - acc_q1[na + k], 35);
    end
    check("b2b_frame0", (hist1.size() > h0) ? hist1[h0] : 16'hFFFF, 16'h0C00);
    check("b2b_frame1", (hist1.size() > h0 + 1) ? hist1[h0 + 1] : 16'hFFFF, 16'h0C02);
    check("b2b_gap", (gap_q1.size() > 1) ? gap_q1[1] : -1, 3);

    // reset after the 7th falling edge
    prev = frames_seen[0];
    d0   = done_cnt[0];
    start(0, 16'h5555);
    t = 0;
    while (fall_cnt[0] < 7 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check("abort_wait_timeout", 1, 0);
    #2 reset = 1'b1;
    #1 check("abort_outs", {27'd0, outs(0)}, 32'h16);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cnt[0] - d0, 0);
    check("abort_no_frame", frames_seen[0] - prev, 0);
    send(0, 16'hA5A0, 16'h025A, "after_abort");

    // valid pulses during SHIFT and GAP are ignored
    prev = frames_seen[0];
    d0   = done_cnt[0];
    start(0, 16'h0010);
    repeat (5) @(negedge clk);
    pulse(0, 16'h1234);
    repeat (64) @(negedge clk);
    pulse(0, 16'h5678);
    repeat (58) @(negedge clk);
    pulse(0, 16'h9ABC);
    repeat (20) @(negedge clk);
    check("pulse_frames", frames_seen[0] - prev, 1);
    check("pulse_dones", done_cnt[0] - d0, 1);
    check("pulse_frame", last_frame[0], 16'h0801);

    repeat (5) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_protocolo.md
# dac_protocolo

Serial transmitter for the audio path's 12-bit SPI-style DAC (DAC121S101-class: SYNC/SCLK/DIN, 16-bit frame, MSB first, DAC samples DIN on SCLK falling edge). It accepts one signed 16-bit filter output sample per valid/ready handshake and converts it to 12-bit offset binary. It then shifts the frame out on a divided serial clock and pulses `done` when the frame completes. It sits at the end of the equalizer chain and is the output-side counterpart of the ADC serial receiver.

## Interface
- `CLK_DIV`, 4: system clocks per SCLK half-period; legal range is ≥1.
- `PD`, 2'b00: DAC power-down bits placed in frame bits [13:12].
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `valid`  in  1  `d_in` is valid; a sample is accepted on the clock edge where `valid && ready`.
- `d_in`  in  16  signed two's-complement sample from the filter.
- `ready`  out  1  high only in IDLE.
- `done`  out  1  one-clock pulse when the frame's SYNC rises.
- `sync`  out  1  DAC SYNC (frame select), active-low.
- `sclk`  out  1  DAC serial clock; idles high.
- `sdata`  out  1  DAC DIN.

## Operation
- All outputs are registered.
- Reset values: `ready`=1, `done`=0, `sync`=1, `sclk`=1, `sdata`=0, state=IDLE, counters=0.
- Conversion: `code[11:0]` = {~d_in[15], d_in[14:4]}. This truncates the 4 LSBs and flips the sign bit to give offset binary.
- Frame word: `frame[15:0]` = {2'b00, PD, code}. It is captured into a shift register on accept.
- After accept, `d_in` and `valid` are ignored until the next IDLE.
- FSM states:
  - IDLE: `sync`=1, `sclk`=1, `sdata`=0, `ready`=1.
    - On `valid && ready`: load the shift register, set `sync`=0, set `sdata`=frame[15], clear counters, go to SHIFT.
  - SHIFT: `div_cnt` counts 0..CLK_DIV-1. At terminal count it wraps to 0 and `sclk` toggles.
    - High→low toggle is a DAC sampling edge; `bit_cnt` increments.
    - Low→high toggle with `bit_cnt`<16: shift left, so `sdata` takes the next bit.
    - Low→high toggle with `bit_cnt`==16: `sync`=1, `sclk`=1, `sdata`=0, `done`=1 for one cycle, go to GAP.
  - GAP: `sync`, `sclk` and `sdata` hold their idle values for 2·CLK_DIV clocks (one SCLK period of SYNC-high time). Then go to IDLE.
- `valid` outside IDLE is ignored. There is no queueing; upstream holds `valid` until `ready`.
- `sdata` changes only on SCLK rising edges, or at SYNC fall. It is always stable across every falling edge.
- Exactly 16 falling edges occur per frame. Every frame is complete unless aborted by reset.
- Reset mid-frame aborts immediately to the reset values. No partial frame resumes and no `done` is issued.
- Width rules: `div_cnt` has ⌈log2(CLK_DIV)⌉ bits (minimum 1). `bit_cnt` has 5 bits.

## Timing
- The accept edge is E0. At E0+0 (registered), `sync`=0, `ready`=0 and `sdata`=frame[15].
- First SCLK falling edge: E0+CLK_DIV. The k-th falling edge (k=1..16) is at E0+(2k−1)·CLK_DIV.
- `sync` is low for exactly 32·CLK_DIV clocks. It rises at E0+32·CLK_DIV, coincident with the final SCLK rise and the `done` pulse.
- `ready` returns high at E0+34·CLK_DIV.
- The earliest next accept is E0+34·CLK_DIV+1, so the minimum sample period is 34·CLK_DIV+1 clocks.
  - CLK_DIV=4: 137 clocks.
  - 100 MHz clk, CLK_DIV=4: SCLK = 12.5 MHz, ≈730 kS/s max.
- If `valid` is held continuously, back-to-back frames are separated by exactly 2·CLK_DIV+1 clocks of SYNC high.

## Test plan
- Reset, then idle 50 clocks → `sync`=1, `sclk`=1, `sdata`=0, `ready`=1, `done`=0 throughout, with no SCLK edges.
- d_in=16'h7FFF, PD=00, CLK_DIV=4 → bits sampled on the 16 SCLK falls = 16'h0FFF. `sync` low for 128 clocks, `done` pulses at E0+128, `ready` at E0+136.
- Conversion sweep:
  - 16'h0000 → frame 16'h0800.
  - 16'h8000 → 16'h0000.
  - 16'hFFF0 → 16'h07FF.
  - 16'h123F → 16'h0923.
  - With PD=2'b11, 16'h0000 → 16'h3800.
- `valid` held high with incrementing `d_in`, CLK_DIV=1 → frames every 35 clocks. Each frame carries the sample present at its accept edge. A `d_in` change mid-frame has no effect.
- Reset asserted after the 7th falling edge → outputs return to reset values asynchronously, no `done` is issued, and the next accepted sample transmits a full 16-bit frame correctly.
- `valid` pulsed during SHIFT and GAP → ignored. Exactly one frame and one `done` per accepted handshake.
